// File: rtl/i2s_pkg.sv
// Shared constants for the i2s_tx transmitter: framing-mode encodings, the underrun
// counter width and the slot offset helper.
package i2s_pkg;

    localparam logic I2S_MODE_I2S   = 1'b1;
    localparam logic I2S_MODE_LJ    = 1'b0;
    localparam int   UNDERRUN_CNT_W = 16;

    // I2S delays the MSB by one bclk after the daclrc edge; left-justified does not.
    function automatic int slot_offset(input logic mode);
        return (mode == I2S_MODE_I2S) ? 1 : 0;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV and emits one-cycle strobes
// on the clk edge where bclk rises or falls.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_LAST);
    assign rise = wrap && !bclk;
    assign fall = wrap && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
            if (wrap) begin
                bclk <= !bclk;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S / left-justified DAC transmitter with a one-deep sample holding
// register. Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                i2s_mode,
    input  logic [SAMPLE_W-1:0] data_left,
    input  logic [SAMPLE_W-1:0] data_right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                daclrc,
    output logic                dacdat,
    output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

    localparam int               FRAME_BITS = 2 * SLOT_W;
    localparam int               CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN   = CNT_W'(SLOT_W);

    logic                bclk_rise_unused;
    logic                bclk_fall;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nxt;
    logic [CNT_W-1:0]    slot_pos;
    logic                frame_start;
    logic                right_slot;
    logic                mode_q;
    logic                mode_eff;
    logic                holding_full;
    logic [SAMPLE_W-1:0] hold_left;
    logic [SAMPLE_W-1:0] hold_right;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;
    logic [SAMPLE_W-1:0] cur_left;
    logic [SAMPLE_W-1:0] cur_right;
    logic [SAMPLE_W-1:0] word;
    logic                dat_nxt;
    int                  bit_pos;

    i2s_bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk_gen (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .bclk (bclk),
        .rise (bclk_rise_unused),
        .fall (bclk_fall)
    );

    // Handshake: a sample transfers on any clock edge where sample_valid && sample_ready;
    // sample_ready is high exactly while the holding register is empty.
    assign sample_ready = !holding_full;

    // Outputs are computed from the post-fall bit position so daclrc/dacdat change with bclk fall.
    always_comb begin
        bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        frame_start = bclk_fall && (bit_cnt_nxt == '0);
        right_slot  = (bit_cnt_nxt >= SLOT_LEN);
        slot_pos    = right_slot ? bit_cnt_nxt - SLOT_LEN : bit_cnt_nxt;
        mode_eff    = frame_start ? i2s_mode : mode_q;
        cur_left    = left_q;
        cur_right   = right_q;
        if (frame_start) begin
            cur_left  = holding_full ? hold_left  : '0;
            cur_right = holding_full ? hold_right : '0;
        end
        word    = right_slot ? cur_right : cur_left;
        bit_pos = int'(slot_pos) - slot_offset(mode_eff);
        dat_nxt = 1'b0;
        for (int b = 0; b < SAMPLE_W; b++) begin
            if (bit_pos == SAMPLE_W - 1 - b) begin
                dat_nxt = word[b];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt      <= CNT_LAST;
            daclrc       <= 1'b0;
            dacdat       <= 1'b0;
            underrun     <= 1'b0;
            mode_q       <= I2S_MODE_LJ;
            left_q       <= '0;
            right_q      <= '0;
            holding_full <= 1'b0;
            hold_left    <= '0;
            hold_right   <= '0;
        end else begin
            underrun <= frame_start && !holding_full;
            if (bclk_fall) begin
                bit_cnt <= bit_cnt_nxt;
                daclrc  <= right_slot;
                dacdat  <= dat_nxt;
            end
            if (frame_start) begin
                mode_q  <= i2s_mode;
                left_q  <= cur_left;
                right_q <= cur_right;
            end
            // A transfer needs an empty register and a drain needs a full one, so they never collide.
            if (sample_valid && !holding_full) begin
                hold_left    <= data_left;
                hold_right   <= data_right;
                holding_full <= 1'b1;
            end else if (frame_start) begin
                holding_full <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != '1)) begin
            underrun_count <= underrun_count + UNDERRUN_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: random stereo traffic, a frame-level reference model
// feeding an expected queue, and a bclk-rise monitor that rebuilds each frame and compares.
module tb_i2s_tx;

    localparam int W  = 24;
    localparam int S  = 32;
    localparam int D  = 4;
    localparam int FC = 4 * S * D;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         i2s_mode;
    logic [W-1:0] data_left;
    logic [W-1:0] data_right;
    logic         sample_valid;
    logic         sample_ready;
    logic         bclk;
    logic         daclrc;
    logic         dacdat;
    logic         underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]  underrun_count;
`endif

    i2s_tx #(
        .SAMPLE_W(W),
        .SLOT_W  (S),
        .BCLK_DIV(D)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .i2s_mode    (i2s_mode),
        .data_left   (data_left),
        .data_right  (data_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bclk        (bclk),
        .daclrc      (daclrc),
        .dacdat      (dacdat),
        .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 sys_clk = !sys_clk;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           edge_num = 0;
    int           und_total = 0;
    int           frames_checked = 0;
    logic         pend_valid = 1'b0;
    logic [W-1:0] pend_l, pend_r;
    // Packed expectation: {underrun, mode, left, right}
    logic [2*W+1:0] exp_q[$];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_num);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame starts every FC cycles from edge 2*D; it plays whatever was accepted since
    // the previous frame start, or zeros with an underrun. A sample accepted on the very
    // frame-start edge belongs to the following frame.
    initial forever begin
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            edge_num   = 0;
            pend_valid = 1'b0;
            und_total  = 0;
            exp_q.delete();
        end else begin
            edge_num++;
            if (edge_num >= 2 * D && ((edge_num - 2 * D) % FC) == 0) begin
                if (pend_valid) begin
                    exp_q.push_back({1'b0, i2s_mode, pend_l, pend_r});
                end else begin
                    exp_q.push_back({1'b1, i2s_mode, {W{1'b0}}, {W{1'b0}}});
                    und_total++;
                end
                pend_valid = 1'b0;
            end
            if (sample_valid && sample_ready) begin
                check(!pend_valid, "single_accept_per_frame", 64'(pend_valid), 64'd0);
                pend_l     = data_left;
                pend_r     = data_right;
                pend_valid = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int             rise_idx;
    int             und_cnt;
    int             mon_p, mon_o;
    logic           prev_bclk, seen_rise, seen_fall;
    logic [2*S-1:0] lrc_bits, dat_bits, lrc_e, dat_e;
    logic [2*W+1:0] mon_e;
    logic [W-1:0]   mon_word;

    initial forever begin
        @(negedge sys_clk);
        if (!sys_rst_n) begin
            rise_idx  = 0;
            und_cnt   = 0;
            prev_bclk = 1'b0;
            seen_rise = 1'b0;
            seen_fall = 1'b0;
        end else begin
            check(sample_ready === !pend_valid, "sample_ready", 64'(sample_ready), 64'(!pend_valid));
            if (underrun === 1'b1) und_cnt++;
            if (bclk && !prev_bclk) begin
                if (!seen_rise) begin
                    check(edge_num == D, "first_rise_cycle", 64'(edge_num), 64'(D));
                    seen_rise = 1'b1;
                end
                if (seen_fall) begin
                    lrc_bits[rise_idx] = daclrc;
                    dat_bits[rise_idx] = dacdat;
                    rise_idx++;
                    if (rise_idx == 2 * S) begin
                        if (exp_q.size() == 0) begin
                            check(1'b0, "frame_without_expectation", 64'(frames_checked), 64'd0);
                        end else begin
                            mon_e = exp_q.pop_front();
                            mon_o = mon_e[2*W] ? 1 : 0;
                            lrc_e = '0;
                            dat_e = '0;
                            for (int b = 0; b < 2 * S; b++) begin
                                mon_p    = b % S;
                                mon_word = (b < S) ? mon_e[2*W-1:W] : mon_e[W-1:0];
                                lrc_e[b] = (b >= S);
                                if (mon_p >= mon_o && mon_p < mon_o + W) dat_e[b] = mon_word[W-1-(mon_p-mon_o)];
                            end
                            check(lrc_bits === lrc_e, "daclrc_frame", 64'(lrc_bits), 64'(lrc_e));
                            check(dat_bits === dat_e, "dacdat_frame", 64'(dat_bits), 64'(dat_e));
                            check(und_cnt == int'(mon_e[2*W+1]), "underrun_pulses", 64'(und_cnt), 64'(mon_e[2*W+1]));
`ifdef I2S_TX_UNDERRUN_CNT_EN
                            check(underrun_count == 16'(und_total), "underrun_count", 64'(underrun_count), 64'(und_total));
`endif
                            frames_checked++;
                        end
                        rise_idx = 0;
                        und_cnt  = 0;
                    end
                end
            end
            if (!bclk && prev_bclk && !seen_fall) begin
                check(edge_num == 2 * D, "first_fall_cycle", 64'(edge_num), 64'(2 * D));
                seen_fall = 1'b1;
            end
            prev_bclk = bclk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check({bclk, daclrc, dacdat, underrun, sample_ready} === 5'b00001, "reset_outputs",
              64'({bclk, daclrc, dacdat, underrun, sample_ready}), 64'(5'b00001));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check(underrun_count === 16'd0, "reset_underrun_count", 64'(underrun_count), 64'd0);
`endif
        repeat (cycles) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int budget;
        budget       = 3 * FC;
        data_left    = l;
        data_right   = r;
        sample_valid = 1'b1;
        while (!sample_ready && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
        check(budget > 0, "accept_timeout", 64'(budget), 64'd1);
        @(negedge sys_clk);
        sample_valid = 1'b0;
    endtask

    // Valid held high; data is replaced only after each accept, mode wanders mid-frame.
    task automatic stream(input int cycles);
        logic took;
        took         = 1'b0;
        data_left    = W'($urandom);
        data_right   = W'($urandom);
        sample_valid = 1'b1;
        repeat (cycles) begin
            @(negedge sys_clk);
            if (took) begin
                data_left  = W'($urandom);
                data_right = W'($urandom);
            end
            took = sample_ready;
            if ($urandom_range(0, 299) == 0) i2s_mode = 1'($urandom_range(0, 1));
        end
        sample_valid = 1'b0;
    endtask

    function automatic int next_frame_edge(input int e);
        if (e < 2 * D) return 2 * D;
        return 2 * D + ((e - 2 * D) / FC + 1) * FC;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int nf;
        sys_rst_n    = 1'b0;
        i2s_mode     = 1'b1;
        data_left    = 24'hA5A5A5;
        data_right   = 24'h5A5A5A;
        sample_valid = 1'b1;

        // I2S, fixed pattern offered before reset release
        do_reset(3);
        send(24'hA5A5A5, 24'h5A5A5A);
        wait_cycles(2 * FC);

        // Left-justified boundary pattern
        i2s_mode = 1'b0;
        send(24'h800001, W'($urandom));
        wait_cycles(2 * FC);

        // No traffic after reset: underrun exactly at edge 2*D
        do_reset(3);
        wait_cycles(2 * D - 1);
        check(underrun === 1'b0, "underrun_before_frame", 64'(underrun), 64'd0);
        wait_cycles(1);
        check(underrun === 1'b1, "underrun_at_first_frame", 64'(underrun), 64'd1);
        wait_cycles(1);
        check(underrun === 1'b0, "underrun_one_cycle", 64'(underrun), 64'd0);
        wait_cycles(FC);

        // Valid raised exactly on a frame-start edge with holding empty
        i2s_mode = 1'b1;
        nf = next_frame_edge(edge_num);
        wait_cycles(nf - 1 - edge_num);
        data_left    = W'($urandom);
        data_right   = W'($urandom);
        sample_valid = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
        wait_cycles(2 * FC);

        // Continuous valid
        stream(8 * FC);

        // Sparse random traffic
        for (int i = 0; i < 6; i++) begin
            wait_cycles($urandom_range(1, FC));
            i2s_mode = 1'($urandom_range(0, 1));
            send(W'($urandom), W'($urandom));
        end
        wait_cycles(FC);

        // Reset in the middle of a frame, at bit position 40
        nf = next_frame_edge(edge_num);
        wait_cycles(nf + 40 * 2 * D - edge_num);
        do_reset(4);
        stream(2 * FC + 4 * D);
        wait_cycles(FC);

        check(frames_checked >= 15, "frames_checked", 64'(frames_checked), 64'd15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
